// File: rtl/serial_shift_tx.sv
// rtl/serial_shift_tx.sv - framed parallel-to-serial transmitter
// Sends start, DATA_W data bits, optional parity and stop, each CLKS_PER_BIT clocks long.
module serial_shift_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 5208,
  parameter int LSB_FIRST    = 1,
  parameter int PARITY       = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              tx,
  output logic              busy,
  output logic              bit_tick
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int PRE_W = $clog2(CLKS_PER_BIT);
  localparam bit HAS_PAR = (PARITY == 1) || (PARITY == 2);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t            state, state_next;
  logic [PRE_W-1:0]  pre, pre_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [DATA_W-1:0] shreg, shreg_next;
  logic              par_bit, par_next;
  logic              tx_next, bit_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pre      <= '0;
      cnt      <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      tx       <= 1'b1;
      in_ready <= 1'b1;
      busy     <= 1'b0;
      bit_tick <= 1'b0;
    end else begin
      state    <= state_next;
      pre      <= pre_next;
      cnt      <= cnt_next;
      shreg    <= shreg_next;
      par_bit  <= par_next;
      tx       <= tx_next;
      in_ready <= (state_next == IDLE);
      busy     <= (state_next != IDLE);
      bit_tick <= (state_next != IDLE) && (pre_next == PRE_LAST);
    end
  end

  always_comb begin
    state_next = state;
    pre_next   = pre;
    cnt_next   = cnt;
    shreg_next = shreg;
    par_next   = par_bit;
    tx_next    = 1'b1;
    bit_end    = (pre == PRE_LAST);

    case (state)
      IDLE: begin
        if (in_valid) begin
          state_next = START;
          pre_next   = '0;
          shreg_next = in_data;
          par_next   = (^in_data) ^ (PARITY == 2);
        end
      end
      START: begin
        if (bit_end) begin
          state_next = DATA;
          pre_next   = '0;
          cnt_next   = '0;
        end else begin
          pre_next = pre + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          pre_next   = '0;
          shreg_next = (LSB_FIRST != 0) ? (shreg >> 1) : (shreg << 1);
          if (cnt == CNT_LAST) begin
            state_next = HAS_PAR ? PAR : STOP;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end else begin
          pre_next = pre + 1'b1;
        end
      end
      PAR: begin
        if (bit_end) begin
          state_next = STOP;
          pre_next   = '0;
        end else begin
          pre_next = pre + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_next = IDLE;
          pre_next   = '0;
        end else begin
          pre_next = pre + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // Line level is derived from the next state so tx itself stays a register.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = (LSB_FIRST != 0) ? shreg_next[0] : shreg_next[DATA_W-1];
      PAR:     tx_next = par_next;
      default: tx_next = 1'b1;
    endcase
  end

endmodule
